decoder_7seg_f: RTL and testbench
=================================

Name: decoder_7seg_f

Overview:
- Registered three-digit BCD-to-seven-segment decoder for the microwave timer display (M:SS).
- Inputs are minutes, tens of seconds and ones of seconds, each 4-bit BCD.
- Each digit is decoded independently into a 7-bit segment pattern.
- Sits between the countdown timer and the display pins.

Parameters:
- INVALID_PATTERN, 7'b0000001, segment pattern driven for any non-BCD code (4'hA–4'hF). Default is the centre bar "-".

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- min  input  4  minutes digit, BCD.
- sec_tens  input  4  tens-of-seconds digit, BCD.
- sec_ones  input  4  ones-of-seconds digit, BCD.
- min_segs  output  7  segment pattern for min.
- sec_tens_segs  output  7  segment pattern for sec_tens.
- sec_ones_segs  output  7  segment pattern for sec_ones.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Segment bit order: [6]=a, [5]=b, [4]=c, [3]=d, [2]=e, [1]=f, [0]=g. Active-high: 1 = segment lit.
- Decode table:
  - 0=7'h7E, 1=7'h30, 2=7'h6D, 3=7'h79, 4=7'h33
  - 5=7'h5B, 6=7'h5F, 7=7'h70, 8=7'h7F, 9=7'h7B
  - 4'hA–4'hF = INVALID_PATTERN
- The same decode function applies to all three digits. There is no range restriction per digit; e.g. sec_tens=7 shows "7".
- Outputs are registered: input sampled at rising edge N appears on outputs after edge N (one-cycle latency). Outputs are stable between edges.
- No handshake; inputs are sampled every cycle.
- Reset: while rst_n=0, all three outputs are 7'h00 (blank), taking effect immediately and independent of clk.
- After rst_n deasserts, the first rising edge loads decoded values.
- Reset asserted mid-operation blanks the outputs asynchronously; inputs during reset are ignored.
- Invalid codes on one digit do not affect the other digits.
- X/Z inputs need not be handled specially; simulation may propagate X.

Optional Feature:
- Macro LEADING_ZERO_BLANK_EN.
- When defined: if min==0, min_segs registers 7'h00 (blank) instead of 7'h7E. The seconds digits are always shown.
- When undefined: min==0 displays "0" (7'h7E).
- Either way, the reset value and latency are unchanged.

Decomposition:
- Shared package decoder_7seg_pkg holds:
  - segment pattern constants SEG_0 … SEG_9, SEG_BLANK, SEG_DASH;
  - typedef seg_t (7-bit) and bcd_t (4-bit);
  - the bit-order definition.
- One combinational sub-module, bcd_to_seg (bcd_t in, seg_t out), instantiated three times.
- Top level holds the three output registers and the optional leading-zero blanking.

Test Plan:
- Reset: hold rst_n=0 with min=5, sec_tens=3, sec_ones=9 -> all outputs 7'h00. Assert rst_n=0 asynchronously mid-cycle -> outputs go to 0 without a clock edge.
- Sweep: after reset, apply (min,sec_tens,sec_ones) = (0,1,2), (1,2,3) … (9,0,1), one per cycle. Each output matches the table one cycle later, e.g. (0,1,2) -> 7'h7E, 7'h30, 7'h6D.
- Invalid: apply (4'hF, 4'hA, 4'hD) -> all three outputs 7'h01. Apply (4'hB, 4, 4'hC) -> 7'h01, 7'h33, 7'h01.
- Latency: change inputs from (8,9,0) to (2,5,7) between edges. Outputs hold 7'h7F, 7'h7B, 7'h7E until the next rising edge, then become 7'h6D, 7'h5B, 7'h70.
- Leading-zero option: with LEADING_ZERO_BLANK_EN defined, apply (0,4,5) -> 7'h00, 7'h33, 7'h5B. Without the macro -> 7'h7E, 7'h33, 7'h5B.

Source files
------------

// File: rtl/decoder_7seg_pkg.sv
// Shared types and segment patterns for the M:SS seven-segment display decoder.
// Segment bit order is [6]=a [5]=b [4]=c [3]=d [2]=e [1]=f [0]=g, active-high (1 = lit).
package decoder_7seg_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] bcd_t;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam seg_t SEG_0     = 7'h7E;
    localparam seg_t SEG_1     = 7'h30;
    localparam seg_t SEG_2     = 7'h6D;
    localparam seg_t SEG_3     = 7'h79;
    localparam seg_t SEG_4     = 7'h33;
    localparam seg_t SEG_5     = 7'h5B;
    localparam seg_t SEG_6     = 7'h5F;
    localparam seg_t SEG_7     = 7'h70;
    localparam seg_t SEG_8     = 7'h7F;
    localparam seg_t SEG_9     = 7'h7B;
    localparam seg_t SEG_BLANK = 7'h00;
    localparam seg_t SEG_DASH  = 7'h01;

endpackage

// File: rtl/decoder_7seg_f_bcd_to_seg.sv
// Combinational BCD-to-seven-segment lookup; codes above 9 map to INVALID_PATTERN.
module bcd_to_seg
    import decoder_7seg_pkg::*;
#(
    parameter seg_t INVALID_PATTERN = SEG_DASH
) (
    input  bcd_t bcd,
    output seg_t segs
);

    always_comb begin
        segs = INVALID_PATTERN;
        case (bcd)
            4'd0: segs = SEG_0;
            4'd1: segs = SEG_1;
            4'd2: segs = SEG_2;
            4'd3: segs = SEG_3;
            4'd4: segs = SEG_4;
            4'd5: segs = SEG_5;
            4'd6: segs = SEG_6;
            4'd7: segs = SEG_7;
            4'd8: segs = SEG_8;
            4'd9: segs = SEG_9;
            default: segs = INVALID_PATTERN;
        endcase
    end

endmodule

// File: rtl/decoder_7seg_f.sv
// Registered three-digit (M:SS) BCD-to-seven-segment decoder with one-cycle latency.
// Define LEADING_ZERO_BLANK_EN to blank the minutes digit when it is zero.
module decoder_7seg_f
    import decoder_7seg_pkg::*;
#(
    parameter seg_t INVALID_PATTERN = SEG_DASH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] min,
    input  logic [3:0] sec_tens,
    input  logic [3:0] sec_ones,
    output logic [6:0] min_segs,
    output logic [6:0] sec_tens_segs,
    output logic [6:0] sec_ones_segs
);

    seg_t min_dec;
    seg_t sec_tens_dec;
    seg_t sec_ones_dec;
    seg_t min_next;

    bcd_to_seg #(.INVALID_PATTERN(INVALID_PATTERN)) u_dec_min (
        .bcd  (min),
        .segs (min_dec)
    );

    bcd_to_seg #(.INVALID_PATTERN(INVALID_PATTERN)) u_dec_sec_tens (
        .bcd  (sec_tens),
        .segs (sec_tens_dec)
    );

    bcd_to_seg #(.INVALID_PATTERN(INVALID_PATTERN)) u_dec_sec_ones (
        .bcd  (sec_ones),
        .segs (sec_ones_dec)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Only the minutes digit is a leading position; seconds always show.
    assign min_next = (min == 4'd0) ? SEG_BLANK : min_dec;
`else
    assign min_next = min_dec;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_segs      <= SEG_BLANK;
            sec_tens_segs <= SEG_BLANK;
            sec_ones_segs <= SEG_BLANK;
        end else begin
            min_segs      <= min_next;
            sec_tens_segs <= sec_tens_dec;
            sec_ones_segs <= sec_ones_dec;
        end
    end

endmodule

// File: tb/tb_decoder_7seg_f.sv
// Directed self-checking bench for decoder_7seg_f (honours LEADING_ZERO_BLANK_EN).
module tb_decoder_7seg_f;

    logic       clk;
    logic       rst_n;
    logic [3:0] min;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [6:0] min_segs;
    logic [6:0] sec_tens_segs;
    logic [6:0] sec_ones_segs;

    int checks = 0;
    int errors = 0;

    decoder_7seg_f dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .min           (min),
        .sec_tens      (sec_tens),
        .sec_ones      (sec_ones),
        .min_segs      (min_segs),
        .sec_tens_segs (sec_tens_segs),
        .sec_ones_segs (sec_ones_segs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'h7E;
            4'd1: return 7'h30;
            4'd2: return 7'h6D;
            4'd3: return 7'h79;
            4'd4: return 7'h33;
            4'd5: return 7'h5B;
            4'd6: return 7'h5F;
            4'd7: return 7'h70;
            4'd8: return 7'h7F;
            4'd9: return 7'h7B;
            default: return 7'h01;
        endcase
    endfunction

    function automatic logic [6:0] ref_min(input logic [3:0] d);
`ifdef LEADING_ZERO_BLANK_EN
        if (d == 4'd0) return 7'h00;
`endif
        return ref_seg(d);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        min = 4'd5; sec_tens = 4'd3; sec_ones = 4'd9;
        #1;
        checks++;
        if ({min_segs, sec_tens_segs, sec_ones_segs} !== 21'h0) begin
            errors++;
            $display("FAIL reset_initial: got %h %h %h, want 00 00 00", min_segs, sec_tens_segs, sec_ones_segs);
        end
        tick(); tick();
        checks++;
        if ({min_segs, sec_tens_segs, sec_ones_segs} !== 21'h0) begin
            errors++;
            $display("FAIL reset_held: got %h %h %h, want 00 00 00", min_segs, sec_tens_segs, sec_ones_segs);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (min_segs !== 7'h5B || sec_tens_segs !== 7'h79 || sec_ones_segs !== 7'h7B) begin
            errors++;
            $display("FAIL reset_first_load: got %h %h %h, want 5b 79 7b", min_segs, sec_tens_segs, sec_ones_segs);
        end
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 10; i++) begin
            logic [3:0] a, b, c;
            a = 4'(i); b = 4'((i + 1) % 10); c = 4'((i + 2) % 10);
            min = a; sec_tens = b; sec_ones = c;
            tick();
            checks++;
            if (min_segs !== ref_min(a) || sec_tens_segs !== ref_seg(b) || sec_ones_segs !== ref_seg(c)) begin
                errors++;
                $display("FAIL sweep_%0d: got %h %h %h, want %h %h %h", i, min_segs, sec_tens_segs, sec_ones_segs,
                         ref_min(a), ref_seg(b), ref_seg(c));
            end
        end
    endtask

    task automatic test_invalid();
        min = 4'hF; sec_tens = 4'hA; sec_ones = 4'hD;
        tick();
        checks++;
        if (min_segs !== 7'h01 || sec_tens_segs !== 7'h01 || sec_ones_segs !== 7'h01) begin
            errors++;
            $display("FAIL invalid_all: got %h %h %h, want 01 01 01", min_segs, sec_tens_segs, sec_ones_segs);
        end
        min = 4'hB; sec_tens = 4'd4; sec_ones = 4'hC;
        tick();
        checks++;
        if (min_segs !== 7'h01 || sec_tens_segs !== 7'h33 || sec_ones_segs !== 7'h01) begin
            errors++;
            $display("FAIL invalid_mixed: got %h %h %h, want 01 33 01", min_segs, sec_tens_segs, sec_ones_segs);
        end
        min = 4'hE; sec_tens = 4'hB; sec_ones = 4'd6;
        tick();
        checks++;
        if (min_segs !== 7'h01 || sec_tens_segs !== 7'h01 || sec_ones_segs !== 7'h5F) begin
            errors++;
            $display("FAIL invalid_edge: got %h %h %h, want 01 01 5f", min_segs, sec_tens_segs, sec_ones_segs);
        end
    endtask

    task automatic test_latency();
        min = 4'd8; sec_tens = 4'd9; sec_ones = 4'd0;
        tick();
        checks++;
        if (min_segs !== 7'h7F || sec_tens_segs !== 7'h7B || sec_ones_segs !== 7'h7E) begin
            errors++;
            $display("FAIL latency_first: got %h %h %h, want 7f 7b 7e", min_segs, sec_tens_segs, sec_ones_segs);
        end
        #2;
        min = 4'd2; sec_tens = 4'd5; sec_ones = 4'd7;
        #3;
        checks++;
        if (min_segs !== 7'h7F || sec_tens_segs !== 7'h7B || sec_ones_segs !== 7'h7E) begin
            errors++;
            $display("FAIL latency_hold: got %h %h %h, want 7f 7b 7e", min_segs, sec_tens_segs, sec_ones_segs);
        end
        tick();
        checks++;
        if (min_segs !== 7'h6D || sec_tens_segs !== 7'h5B || sec_ones_segs !== 7'h70) begin
            errors++;
            $display("FAIL latency_update: got %h %h %h, want 6d 5b 70", min_segs, sec_tens_segs, sec_ones_segs);
        end
    endtask

    task automatic test_leading_zero();
        logic [6:0] want_min;
`ifdef LEADING_ZERO_BLANK_EN
        want_min = 7'h00;
`else
        want_min = 7'h7E;
`endif
        min = 4'd0; sec_tens = 4'd4; sec_ones = 4'd5;
        tick();
        checks++;
        if (min_segs !== want_min || sec_tens_segs !== 7'h33 || sec_ones_segs !== 7'h5B) begin
            errors++;
            $display("FAIL leading_zero: got %h %h %h, want %h 33 5b", min_segs, sec_tens_segs, sec_ones_segs, want_min);
        end
        min = 4'd1; sec_tens = 4'd0; sec_ones = 4'd0;
        tick();
        checks++;
        if (min_segs !== 7'h30 || sec_tens_segs !== 7'h7E || sec_ones_segs !== 7'h7E) begin
            errors++;
            $display("FAIL seconds_zero_shown: got %h %h %h, want 30 7e 7e", min_segs, sec_tens_segs, sec_ones_segs);
        end
    endtask

    task automatic test_async_reset();
        min = 4'd7; sec_tens = 4'd7; sec_ones = 4'd7;
        tick();
        checks++;
        if (min_segs !== 7'h70 || sec_tens_segs !== 7'h70 || sec_ones_segs !== 7'h70) begin
            errors++;
            $display("FAIL pre_async: got %h %h %h, want 70 70 70", min_segs, sec_tens_segs, sec_ones_segs);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({min_segs, sec_tens_segs, sec_ones_segs} !== 21'h0) begin
            errors++;
            $display("FAIL async_reset: got %h %h %h, want 00 00 00", min_segs, sec_tens_segs, sec_ones_segs);
        end
        min = 4'd3; sec_tens = 4'd1; sec_ones = 4'd8;
        tick();
        checks++;
        if ({min_segs, sec_tens_segs, sec_ones_segs} !== 21'h0) begin
            errors++;
            $display("FAIL async_reset_held: got %h %h %h, want 00 00 00", min_segs, sec_tens_segs, sec_ones_segs);
        end
        #2;
        rst_n = 1'b1;
        tick();
        checks++;
        if (min_segs !== 7'h79 || sec_tens_segs !== 7'h30 || sec_ones_segs !== 7'h7F) begin
            errors++;
            $display("FAIL async_reset_release: got %h %h %h, want 79 30 7f", min_segs, sec_tens_segs, sec_ones_segs);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_invalid();
        test_latency();
        test_leading_zero();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
